decimal_entry_to_binary: RTL and testbench
==========================================

Name: decimal_entry_to_binary

Overview:
Sequential decimal-to-binary converter for operator numeric entry (e.g. the bet amount). Accepts BCD digits one at a time, shifts each in at the ones position, and keeps the BCD buffer available for the seven-segment display path. On commit, an iterative multiply-by-10-and-add FSM produces a clamped binary value for the game logic.

Parameters:
NUM_DIGITS, 4, decimal digits held in the entry buffer (1..4)
OUT_W, 16, width of the binary result
MAX_VALUE, 2000, largest legal result; larger results are clamped and flagged

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous reset, active-high
digit_valid  input  1  one-cycle strobe: digit is presented
digit  input  4  BCD digit code
commit  input  1  one-cycle strobe: convert the buffer
clear  input  1  empty the buffer / abort a conversion
bcd  output  4*NUM_DIGITS  entry buffer; ones digit in [3:0]
digit_count  output  3  digits currently held (0..NUM_DIGITS)
entry_full  output  1  digit_count == NUM_DIGITS
busy  output  1  high in CONVERT and DONE
value  output  OUT_W  last converted result (held)
value_valid  output  1  one-cycle pulse when value updates
range_err  output  1  one-cycle pulse with value_valid if clamped

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; bcd=0, digit_count=0, value=0. Outputs value_valid, range_err and busy are 0. Reset overrides everything, including mid-conversion.
- States: IDLE, CONVERT, DONE.
- IDLE priority, highest first:
  - clear: bcd=0, digit_count=0.
  - commit: go to CONVERT, acc=0, idx=NUM_DIGITS-1. A digit_valid in the same cycle is dropped.
  - digit_valid with digit<=9 and !entry_full: bcd = {bcd[4*NUM_DIGITS-5:0], digit}, digit_count+1.
  - digit_valid with digit>9 or entry_full: ignored, no state change.
- commit with digit_count==0 still converts and yields value=0 with a value_valid pulse.
- CONVERT: each cycle acc = acc*10 + bcd[4*idx+3:4*idx], then idx decrements. After the idx=0 cycle, go to DONE. The state lasts exactly NUM_DIGITS cycles.
- acc width: internal accumulator is wide enough for 10^NUM_DIGITS-1 (14 bits for 4 digits). No overflow inside acc.
- DONE (one cycle):
  - value = (acc > MAX_VALUE) ? MAX_VALUE : acc[OUT_W-1:0].
  - value_valid=1; range_err=1 if clamped.
  - bcd=0, digit_count=0; then IDLE.
- Latency: commit sampled at edge k gives value_valid high during the cycle after edge k+NUM_DIGITS+1, which is 5 cycles for the default.
- During CONVERT/DONE:
  - digit_valid and commit are ignored (dropped, not queued).
  - clear in CONVERT aborts to IDLE: bcd=0, digit_count=0, value unchanged, no value_valid.
  - clear in DONE is ignored, because the result is already being published.
- value holds between conversions; value_valid/range_err never high for more than one cycle.

Optional Feature:
Macro DECIMAL_ENTRY_BACKSPACE_EN.
- Defined: in IDLE, digit_valid with digit==4'hA is a backspace.
  - Effect: bcd = bcd >> 4 (logical shift, high digit zero-filled), digit_count-1.
  - When digit_count==0 it is ignored.
  - Backspace is accepted even when entry_full.
  - Priority: below clear and commit.
- Not defined: 4'hA is treated like any code >9 and ignored.

Test Plan:
1. Reset, then digits 1,2,5 strobed, then commit -> bcd=16'h0125, digit_count=3; exactly 5 cycles later value=125, value_valid 1 cycle, range_err=0, buffer cleared.
2. Digits 9,9,9,9 then commit (MAX_VALUE=2000) -> value=2000, range_err=1 with value_valid. Also a fifth digit 7 before commit is dropped: bcd stays 16'h9999, entry_full=1.
3. Digits 4, then code 4'hC, then 2 -> bcd=16'h0042, digit_count=2. Same cycle digit_valid=7 with commit -> 7 dropped, value=42.
4. Commit 1500, assert clear 2 cycles into CONVERT -> no value_valid, value keeps previous (42), bcd=0, busy drops next cycle. Repeat with rst mid-CONVERT -> all outputs 0.
5. Commit with empty buffer -> value=0 with value_valid pulse, range_err=0.
6. With DECIMAL_ENTRY_BACKSPACE_EN: digits 3,8, backspace, 6, commit -> value=36. Backspace on an empty buffer leaves digit_count=0. Without the macro, code 4'hA is ignored and the result is value=386.

Source files
------------

// File: rtl/decimal_entry_to_binary_if.sv
// Entry-side bus of decimal_entry_to_binary: digit/commit/clear strobes in, BCD buffer and result out.
// master drives the strobes (keypad logic / bench); slave is the converter. dbg_state mirrors the FSM.
interface decimal_entry_to_binary_if #(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_W      = 16
);
  logic                    digit_valid;
  logic [3:0]              digit;
  logic                    commit;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [2:0]              digit_count;
  logic                    entry_full;
  logic                    busy;
  logic [OUT_W-1:0]        value;
  logic                    value_valid;
  logic                    range_err;
  logic [1:0]              dbg_state;

  // Strobes are single-cycle and unacknowledged: a strobe the converter cannot
  // use in that cycle is dropped, never held or queued; value_valid/range_err
  // are single-cycle pulses with no ready back-pressure.
  modport master (
    output digit_valid, digit, commit, clear,
    input  bcd, digit_count, entry_full, busy, value, value_valid, range_err, dbg_state
  );

  modport slave (
    input  digit_valid, digit, commit, clear,
    output bcd, digit_count, entry_full, busy, value, value_valid, range_err, dbg_state
  );
endinterface

// File: rtl/decimal_entry_to_binary.sv
// Operator decimal entry: BCD digits shift in at the ones position; commit runs a multiply-by-10-and-add
// FSM yielding a clamped binary value. Optional backspace (code 4'hA) via DECIMAL_ENTRY_BACKSPACE_EN.
module decimal_entry_to_binary #(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_W      = 16,
  parameter int MAX_VALUE  = 2000
) (
  input  logic                      clk,
  input  logic                      rst,
  decimal_entry_to_binary_if.slave  bus
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int ACC_W = $clog2(10 ** NUM_DIGITS);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  logic [BCD_W-1:0] r_bcd;
  logic [2:0]       r_count;
  logic [ACC_W-1:0] r_acc;
  logic [IDX_W-1:0] r_idx;
  logic [OUT_W-1:0] r_value;
  logic             r_value_valid;
  logic             r_range_err;

  logic             w_full;
  logic             w_digit_ok;
  logic [3:0]       w_cur_digit;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_clamp;

  always_comb begin
    w_full      = (r_count == 3'(NUM_DIGITS));
    w_digit_ok  = (bus.digit <= 4'd9);
    w_cur_digit = r_bcd[{r_idx, 2'b00} +: 4];
    w_acc_next  = (r_acc * ACC_W'(10)) + ACC_W'(w_cur_digit);
    w_clamp     = (32'(r_acc) > 32'(MAX_VALUE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_bcd         <= '0;
      r_count       <= '0;
      r_acc         <= '0;
      r_idx         <= '0;
      r_value       <= '0;
      r_value_valid <= 1'b0;
      r_range_err   <= 1'b0;
    end else begin
      r_value_valid <= 1'b0;
      r_range_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.clear) begin
            r_bcd   <= '0;
            r_count <= '0;
          end else if (bus.commit) begin
            r_state <= S_CONVERT;
            r_acc   <= '0;
            r_idx   <= IDX_W'(NUM_DIGITS - 1);
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
          end else if (bus.digit_valid && bus.digit == 4'hA) begin
            // Backspace works even on a full buffer; on an empty one it is a no-op.
            if (r_count != 3'd0) begin
              r_bcd   <= r_bcd >> 4;
              r_count <= r_count - 3'd1;
            end
`endif
          end else if (bus.digit_valid && w_digit_ok && !w_full) begin
            r_bcd   <= (r_bcd << 4) | BCD_W'(bus.digit);
            r_count <= r_count + 3'd1;
          end
        end
        S_CONVERT: begin
          if (bus.clear) begin
            // Abort: the previous result stays published.
            r_state <= S_IDLE;
            r_bcd   <= '0;
            r_count <= '0;
          end else begin
            // Most significant digit first; unused high digits are zero.
            r_acc <= w_acc_next;
            if (r_idx == '0) r_state <= S_DONE;
            else             r_idx   <= r_idx - IDX_W'(1);
          end
        end
        S_DONE: begin
          r_value       <= w_clamp ? OUT_W'(MAX_VALUE) : OUT_W'(r_acc);
          r_value_valid <= 1'b1;
          r_range_err   <= w_clamp;
          r_bcd         <= '0;
          r_count       <= '0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bcd         = r_bcd;
  assign bus.digit_count = r_count;
  assign bus.entry_full  = w_full;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.value       = r_value;
  assign bus.value_valid = r_value_valid;
  assign bus.range_err   = r_range_err;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_decimal_entry_to_binary.sv
// Bench for decimal_entry_to_binary: directed scenarios plus randomized entry sequences,
// checked against a digit-list model of the entry buffer and a scoreboard of expected results.
module tb_decimal_entry_to_binary;
  localparam int NUM_DIGITS = 4;
  localparam int OUT_W      = 16;
  localparam int MAX_VALUE  = 2000;
  localparam int LATENCY    = NUM_DIGITS + 1;

  logic clk;
  logic rst;

  decimal_entry_to_binary_if #(.NUM_DIGITS(NUM_DIGITS), .OUT_W(OUT_W)) bus ();

  decimal_entry_to_binary #(
    .NUM_DIGITS(NUM_DIGITS),
    .OUT_W     (OUT_W),
    .MAX_VALUE (MAX_VALUE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: the digits on the display, in entry order, plus the last published value.
  int unsigned m_dig[$];
  int unsigned m_value = 0;
  logic [OUT_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_code(input int unsigned c);
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
    if (c == 10) begin
      if (m_dig.size() > 0) void'(m_dig.pop_back());
      return;
    end
`endif
    if (c <= 9 && m_dig.size() < NUM_DIGITS) m_dig.push_back(c);
  endfunction

  function automatic logic [31:0] model_bcd();
    logic [31:0] r = 0;
    foreach (m_dig[i]) r = (r << 4) | 32'(m_dig[i]);
    return r;
  endfunction

  function automatic int unsigned model_number();
    int unsigned n = 0;
    foreach (m_dig[i]) n = n * 10 + m_dig[i];
    return n;
  endfunction

  // ---------------- drivers ----------------
  task automatic send_code(input int unsigned c);
    bus.digit_valid = 1'b1;
    bus.digit       = 4'(c);
    tick();
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    model_code(c);
  endtask

  task automatic check_buffer(input string tag);
    check({tag, ".bcd"},   32'(bus.bcd), model_bcd());
    check({tag, ".count"}, 32'(bus.digit_count), 32'(m_dig.size()));
    check({tag, ".full"},  32'(bus.entry_full), 32'(m_dig.size() == NUM_DIGITS));
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    m_dig.delete();
  endtask

  // Commit with an optional same-cycle digit (extra >= 0) that must be dropped;
  // while busy, random digit/commit strobes are thrown at the DUT and must be ignored.
  task automatic do_commit(input string tag, input int extra, input bit noise);
    int unsigned num;
    int          n;
    logic        exp_rng;
    logic [OUT_W-1:0] exp_v;
    num     = model_number();
    exp_rng = (num > MAX_VALUE);
    exp_q.push_back(exp_rng ? OUT_W'(MAX_VALUE) : OUT_W'(num));
    bus.commit = 1'b1;
    if (extra >= 0) begin
      bus.digit_valid = 1'b1;
      bus.digit       = 4'(extra);
    end
    tick();
    bus.commit      = 1'b0;
    bus.digit_valid = 1'b0;
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    n = 1;
    while (n < 20) begin
      if (noise) begin
        bus.digit_valid = 1'($urandom_range(0, 1));
        bus.digit       = 4'($urandom_range(0, 15));
        bus.commit      = 1'($urandom_range(0, 1));
      end
      tick();
      if (bus.value_valid) break;
      n++;
    end
    bus.digit_valid = 1'b0;
    bus.commit      = 1'b0;
    check({tag, ".latency"}, 32'(n), 32'(LATENCY));
    exp_v = exp_q.pop_front();
    check({tag, ".value"},     32'(bus.value), 32'(exp_v));
    check({tag, ".range_err"}, 32'(bus.range_err), 32'(exp_rng));
    check({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
    m_dig.delete();
    m_value = 32'(exp_v);
    check_buffer({tag, ".after"});
    tick();
    check({tag, ".pulse"}, {30'd0, bus.value_valid, bus.range_err}, 32'd0);
    check({tag, ".hold"},  32'(bus.value), m_value);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    int unsigned exp_t6;
    rst = 1'b1;
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.commit      = 1'b0;
    bus.clear       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset.value", 32'(bus.value), 32'd0);
    check("reset.flags", {29'd0, bus.value_valid, bus.range_err, bus.busy}, 32'd0);
    check_buffer("reset");

    // 1: 1,2,5 -> 125
    send_code(1); send_code(2); send_code(5);
    check("t1.bcd_const", 32'(bus.bcd), 32'h0125);
    check_buffer("t1");
    do_commit("t1", -1, 1'b0);
    check("t1.value_const", 32'(bus.value), 32'd125);

    // 2: 9999 plus dropped fifth digit -> clamped
    send_code(9); send_code(9); send_code(9); send_code(9); send_code(7);
    check("t2.bcd_const", 32'(bus.bcd), 32'h9999);
    check_buffer("t2");
    do_commit("t2", -1, 1'b0);
    check("t2.value_const", 32'(bus.value), 32'd2000);

    // 3: invalid code skipped, same-cycle digit with commit dropped
    send_code(4); send_code(12); send_code(2);
    check("t3.bcd_const", 32'(bus.bcd), 32'h0042);
    check_buffer("t3");
    do_commit("t3", 7, 1'b0);
    check("t3.value_const", 32'(bus.value), 32'd42);

    // 4a: clear two cycles into CONVERT aborts
    send_code(1); send_code(5); send_code(0); send_code(0);
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    m_dig.delete();
    check("t4.busy", 32'(bus.busy), 32'd0);
    check("t4.value", 32'(bus.value), m_value);
    check_buffer("t4");
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.value_valid) seen++;
    end
    check("t4.no_valid", 32'(seen), 32'd0);

    // 4b: reset mid-CONVERT
    send_code(1); send_code(5); send_code(0); send_code(0);
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_dig.delete();
    m_value = 0;
    check("t4r.value", 32'(bus.value), 32'd0);
    check("t4r.flags", {29'd0, bus.value_valid, bus.range_err, bus.busy}, 32'd0);
    check_buffer("t4r");

    // 5: empty commit
    do_commit("t5", -1, 1'b0);
    check("t5.value_const", 32'(bus.value), 32'd0);

    // 6: backspace behaviour (or its absence)
    send_code(10);
    check("t6.empty_bs_count", 32'(bus.digit_count), 32'd0);
    send_code(3); send_code(8); send_code(10); send_code(6);
    check_buffer("t6");
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
    exp_t6 = 36;
`else
    exp_t6 = 386;
`endif
    do_commit("t6", -1, 1'b0);
    check("t6.value_const", 32'(bus.value), exp_t6);

    // Randomized entry sessions
    for (int it = 0; it < 40; it++) begin
      int nd;
      nd = $urandom_range(0, 7);
      for (int k = 0; k < nd; k++) begin
        send_code($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) tick();
      end
      check_buffer("rnd.entry");
      if ($urandom_range(0, 7) == 0) begin
        do_clear();
        check_buffer("rnd.clear");
        send_code($urandom_range(0, 9));
      end
      do_commit("rnd", ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
